// File: rtl/flow_rate_pkg.sv
// flow_rate_pkg
// Shared constants, types and helpers for the multi-channel flow-rate shaper.
//   DEF_*        : default parameter values for flow_rate_shaper_mc
//   STAT_W       : width of the optional per-channel statistics counters
//   rate_t       : rate word at the default RATE_W
//   bitrev()     : reverse the low 'w' bits of a word (w <= BITREV_MAX_W)
// Optional feature macro used by the other files: FLOW_RATE_STATS_EN.
package flow_rate_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_RATE_W   = 7;
  localparam int DEF_CNT_W    = 9;
  localparam int STAT_W       = 16;
  localparam int BITREV_MAX_W = 32;

  typedef logic [DEF_RATE_W-1:0] rate_t;
  typedef logic [STAT_W-1:0]     stat_t;

  // Bits at or above 'w' in the result are zero. 'w' must be an
  // elaboration-time constant for the loop to unroll into plain wiring.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/flow_rate_channel.sv
// flow_rate_channel
// One shaping channel: shadow rate, allowance compare, saturating credit
// counter, Rdy hysteresis, Sat pulse and (with FLOW_RATE_STATS_EN) a
// saturating 16-bit count of Sat pulses.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   enable_i        : 1 = credit logic advances, 0 = hold (shadow reloads)
//   boundary_i      : 1 on the last phase slot of a period while enabled
//   rate_i          : programmed disabled-slot count for this channel
//   ph_rev_i        : bit-reversed shared phase
//   hi_thr_i        : Rdy deassert threshold
//   lo_thr_i        : Rdy reassert threshold
//   flow_i          : channel consumed a slot this cycle
//   stat_clr_i      : synchronous clear of the statistics counter
//   rdy_o           : channel may send
//   sat_o           : increment attempted at counter max (1-cycle pulse)
//   stat_o          : statistics counter (0 when the feature is absent)
module flow_rate_channel
  import flow_rate_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              boundary_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [RATE_W-1:0] ph_rev_i,
  input  logic [CNT_W-1:0]  hi_thr_i,
  input  logic [CNT_W-1:0]  lo_thr_i,
  input  logic              flow_i,
  input  logic              stat_clr_i,
  output logic              rdy_o,
  output logic              sat_o,
  output stat_t             stat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RATE_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              sat_q, sat_d;
  logic              allow;

  always_comb begin
    allow    = (ph_rev_i >= shadow_q);
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
    sat_d    = 1'b0;

    // Rate changes only land on a period boundary (or while idle) so a
    // period is never evaluated against two different rates.
    if (!enable_i || boundary_i) shadow_d = rate_i;

    if (enable_i) begin
      if (flow_i && !allow) begin
        if (cnt_q == CNT_MAX) sat_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (!flow_i && allow) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end

      // Deassert wins, so LoThr >= HiThr degenerates to cnt < HiThr.
      if (cnt_d >= hi_thr_i)      rdy_d = 1'b0;
      else if (cnt_d <= lo_thr_i) rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
      sat_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      sat_q    <= sat_d;
    end
  end

  assign rdy_o = rdy_q;
  assign sat_o = sat_q;

`ifdef FLOW_RATE_STATS_EN
  stat_t stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stat_clr_i)                  stat_d = '0;
    else if (sat_q && stat_q != '1)  stat_d = stat_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign stat_o = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_o          = '0;
`endif

endmodule

// File: rtl/flow_rate_shaper_mc.sv
// flow_rate_shaper_mc
// Multi-channel flow-rate shaper and throttle. A shared phase counter is
// bit-reversed to give an evenly dithered allowance pattern; each channel
// compares its Flow against that pattern with a saturating credit counter
// and drives Rdy back-pressure with hysteresis.
// Optional feature macro: FLOW_RATE_STATS_EN (per-channel Sat statistics).
// Ports:
//   Clk, RstN    : clock (rising edge), asynchronous active-low reset
//   Enable       : 1 = shaping advances, 0 = phase/counters hold
//   DisableRate  : per-channel disabled slots per period, ch c at [c*RATE_W +: RATE_W]
//   HiThr, LoThr : shared Rdy deassert / reassert thresholds
//   Flow         : per-channel slot consumed this cycle
//   Rdy          : per-channel may-send
//   Sat          : per-channel saturation pulse
//   StatClr      : clear statistics counters
//   StatCnt      : per-channel 16-bit statistics, ch c at [c*16 +: 16]
module flow_rate_shaper_mc
  import flow_rate_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int RATE_W = DEF_RATE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     Clk,
  input  logic                     RstN,
  input  logic                     Enable,
  input  logic [NUM_CH*RATE_W-1:0] DisableRate,
  input  logic [CNT_W-1:0]         HiThr,
  input  logic [CNT_W-1:0]         LoThr,
  input  logic [NUM_CH-1:0]        Flow,
  output logic [NUM_CH-1:0]        Rdy,
  output logic [NUM_CH-1:0]        Sat,
  input  logic                     StatClr,
  output logic [NUM_CH*STAT_W-1:0] StatCnt
);

  localparam logic [RATE_W-1:0] PH_MAX = '1;

  logic [RATE_W-1:0]       ph_q, ph_d;
  logic                    boundary;
  logic [BITREV_MAX_W-1:0] ph_rev_wide;
  logic [RATE_W-1:0]       ph_rev;
  logic                    unused_ph_rev_hi;

  always_comb begin
    ph_d = ph_q;
    if (Enable) ph_d = ph_q + 1'b1;  // natural wrap at 2^RATE_W
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) ph_q <= '0;
    else       ph_q <= ph_d;
  end

  assign boundary         = Enable && (ph_q == PH_MAX);
  assign ph_rev_wide      = bitrev(BITREV_MAX_W'(ph_q), RATE_W);
  assign ph_rev           = ph_rev_wide[RATE_W-1:0];
  assign unused_ph_rev_hi = ^ph_rev_wide[BITREV_MAX_W-1:RATE_W];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    flow_rate_channel #(
      .RATE_W (RATE_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk_i      (Clk),
      .rst_ni     (RstN),
      .enable_i   (Enable),
      .boundary_i (boundary),
      .rate_i     (DisableRate[c*RATE_W +: RATE_W]),
      .ph_rev_i   (ph_rev),
      .hi_thr_i   (HiThr),
      .lo_thr_i   (LoThr),
      .flow_i     (Flow[c]),
      .stat_clr_i (StatClr),
      .rdy_o      (Rdy[c]),
      .sat_o      (Sat[c]),
      .stat_o     (StatCnt[c*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_flow_rate_shaper_mc.sv
module tb_flow_rate_shaper_mc;

  localparam int NUM_CH  = 2;
  localparam int RATE_W  = 3;
  localparam int CNT_W   = 4;
  localparam int PERIOD  = 8;
  localparam int CNT_MAX = 15;
  localparam int EXP_W   = 36;  // {stat1, stat0, sat, rdy}

  // ---------------- clock / reset ----------------
  logic                     Clk;
  logic                     RstN;
  logic                     Enable;
  logic [NUM_CH*RATE_W-1:0] DisableRate;
  logic [CNT_W-1:0]         HiThr;
  logic [CNT_W-1:0]         LoThr;
  logic [NUM_CH-1:0]        Flow;
  logic [NUM_CH-1:0]        Rdy;
  logic [NUM_CH-1:0]        Sat;
  logic                     StatClr;
  logic [NUM_CH*16-1:0]     StatCnt;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  flow_rate_shaper_mc #(
    .NUM_CH (NUM_CH),
    .RATE_W (RATE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk         (Clk),
    .RstN        (RstN),
    .Enable      (Enable),
    .DisableRate (DisableRate),
    .HiThr       (HiThr),
    .LoThr       (LoThr),
    .Flow        (Flow),
    .Rdy         (Rdy),
    .Sat         (Sat),
    .StatClr     (StatClr),
    .StatCnt     (StatCnt)
  );

  // ---------------- scoreboard ----------------
  int n_vectors = 0;
  int n_miscmp  = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slot s of a period is allowed for rate r when the bit-reversed slot
  // index is >= r, i.e. the first r entries of the reversed ordering are
  // blocked.
  int m_ph;
  int m_shadow[NUM_CH];
  int m_cnt[NUM_CH];
  int m_stat[NUM_CH];
  bit m_rdy[NUM_CH];
  bit m_sat[NUM_CH];

  function automatic int rev_slot(input int s);
    int r = 0;
    int v = s;
    for (int b = 0; b < RATE_W; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = 0; m_cnt[c] = 0; m_stat[c] = 0;
      m_rdy[c] = 1'b1; m_sat[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit old_sat;
    bit allow;
    logic [EXP_W-1:0] e;
    for (int c = 0; c < NUM_CH; c++) begin
      old_sat = m_sat[c];
      m_sat[c] = 1'b0;
      if (Enable) begin
        allow = (rev_slot(m_ph) >= m_shadow[c]);
        if (Flow[c] && !allow) begin
          if (m_cnt[c] == CNT_MAX) m_sat[c] = 1'b1;
          else m_cnt[c] = m_cnt[c] + 1;
        end else if (!Flow[c] && allow && m_cnt[c] > 0) begin
          m_cnt[c] = m_cnt[c] - 1;
        end
        if (m_cnt[c] >= int'(HiThr))      m_rdy[c] = 1'b0;
        else if (m_cnt[c] <= int'(LoThr)) m_rdy[c] = 1'b1;
      end
`ifdef FLOW_RATE_STATS_EN
      if (StatClr)                           m_stat[c] = 0;
      else if (old_sat && m_stat[c] < 65535) m_stat[c] = m_stat[c] + 1;
`else
      if (old_sat) m_stat[c] = 0;
`endif
      if (!Enable || m_ph == PERIOD - 1) m_shadow[c] = int'(DisableRate[c*RATE_W +: RATE_W]);
    end
    if (Enable) m_ph = (m_ph + 1) % PERIOD;
    e = {m_stat[1][15:0], m_stat[0][15:0], m_sat[1], m_sat[0], m_rdy[1], m_rdy[0]};
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input int r0, input int r1, input logic [1:0] f);
    Enable      = en;
    DisableRate = {RATE_W'(r1), RATE_W'(r0)};
    Flow        = f;
  endtask

  task automatic step();
    logic [EXP_W-1:0] e;
    model_step();
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("rdy",     32'(Rdy),     32'(e[1:0]));
    check("sat",     32'(Sat),     32'(e[3:2]));
    check("statcnt", StatCnt,      e[35:4]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  int sat_pulses;

  initial begin
    RstN = 1'b0; StatClr = 1'b0; HiThr = 4'd8; LoThr = 4'd2;
    drive(1'b0, 0, 0, 2'b00);
    model_reset();
    #12;
    check("reset_rdy", 32'(Rdy), 32'h3);
    check("reset_sat", 32'(Sat), 32'h0);
    check("reset_stat", StatCnt, 32'h0);
    RstN = 1'b1;

    // Rate 0: every slot allowed, Flow never builds credit.
    drive(1'b1, 0, 0, 2'b01);
    steps(16);

    // Rate 4 on ch0 loaded while idle, then run from ph=0.
    drive(1'b0, 4, 0, 2'b00);
    step();
    drive(1'b1, 4, 0, 2'b01);
    steps(8);
    check("rate4_rdy_after8", 32'(Rdy[0]), 32'h1);
    steps(8);
    check("rate4_rdy_at_hi", 32'(Rdy[0]), 32'h0);
    drive(1'b1, 4, 0, 2'b00);
    steps(11);
    check("rate4_rdy_hyst", 32'(Rdy[0]), 32'h0);
    step();
    check("rate4_rdy_at_lo", 32'(Rdy[0]), 32'h1);

    // ch1 at rate 7 saturates and pulses Sat; ch0 idles.
    drive(1'b0, 4, 7, 2'b00);
    step();
    drive(1'b1, 4, 7, 2'b10);
    sat_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Sat[1]) sat_pulses++;
    end
    check("ch1_sat_seen", 32'(sat_pulses > 0), 32'h1);
    check("ch0_unaffected_sat", 32'(Sat[0]), 32'h0);
    StatClr = 1'b1;
    step();
    StatClr = 1'b0;
    drive(1'b1, 4, 7, 2'b00);
    steps(4);

    // Mid-period rate change on ch0 takes effect only after the wrap.
    drive(1'b1, 0, 0, 2'b01);
    for (int i = 0; i < PERIOD && m_ph != 3; i++) step();
    check("ph_at_3", 32'(m_ph), 32'd3);
    drive(1'b1, 7, 0, 2'b01);
    steps(16);

    // Randomized traffic, thresholds, enables and clears.
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        HiThr = CNT_W'($urandom_range(0, 15));
        LoThr = CNT_W'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)) & ((i % 16 < 8) ? 7 : 4),
            int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      StatClr = ($urandom_range(0, 29) == 0);
      step();
    end
    StatClr = 1'b0;

    // Asynchronous reset with ch0 back-pressured.
    HiThr = 4'd8; LoThr = 4'd2;
    drive(1'b0, 7, 0, 2'b00);
    step();
    drive(1'b1, 7, 0, 2'b01);
    steps(12);
    check("pre_reset_rdy0", 32'(Rdy[0]), 32'h0);
    #2;
    RstN = 1'b0;
    #1;
    check("async_rdy", 32'(Rdy), 32'h3);
    check("async_sat", 32'(Sat), 32'h0);
    check("async_stat", StatCnt, 32'h0);
    model_reset();
    #3;
    RstN = 1'b1;
    drive(1'b1, 7, 0, 2'b01);
    steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscmp);
    $finish;
  end

endmodule

// File: doc/flow_rate_shaper_mc.md
Name: flow_rate_shaper_mc

Overview:
- Multi-channel flow-rate shaper and throttle, the parametrised successor of the single-channel flow-rate adjuster.
- Each channel has a runtime-programmable disable rate.
- The block compares actual per-channel Flow against an evenly dithered allowance pattern and keeps a saturating credit counter per channel.
- Rdy back-pressure with hysteresis is driven upstream.
- Sits between traffic sources and the shared link arbiter.

Parameters:
- NUM_CH, 4, number of independent channels.
- RATE_W, 7, rate resolution in bits. Pattern period is 2^RATE_W cycles.
- CNT_W, 9, width of each credit counter. Counter saturates at 2^CNT_W-1.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- RstN  in  1  asynchronous active-low reset.
- Enable  in  1  1 = shaping advances; 0 = phase and counters hold.
- DisableRate  in  NUM_CH*RATE_W  per-channel disabled-slot count per period. Channel c is at [c*RATE_W +: RATE_W].
- HiThr  in  CNT_W  Rdy deassert threshold, shared by all channels.
- LoThr  in  CNT_W  Rdy reassert threshold, shared by all channels.
- Flow  in  NUM_CH  1 = channel consumed a slot this cycle.
- Rdy  out  NUM_CH  1 = channel may send.
- Sat  out  NUM_CH  1-cycle pulse: increment attempted while the counter is at max.
- StatClr  in  1  clears the statistics counters (optional feature).
- StatCnt  out  NUM_CH*16  per-channel statistics counters (optional feature).

Behaviour:
- Reset values (async on RstN=0): phase=0, shadow rates=0, counters=0, Rdy=all 1, Sat=0, StatCnt=0.
- Phase counter ph (RATE_W bits):
  - Increments when Enable=1.
  - Wraps from 2^RATE_W-1 to 0.
  - Holds when Enable=0.
- Shadow rate register per channel loads DisableRate in either case:
  - Enable=1 and ph==2^RATE_W-1 (period boundary), or
  - Enable=0 (idle).
  - Mid-period changes therefore take effect from the next period.
- Allowance: allow[c] = (bitrev(ph) >= shadow[c]). Unsigned compare, RATE_W bits.
  - Gives 2^RATE_W - shadow[c] allowed slots per period, evenly spread.
  - shadow=0 means every slot is allowed.
  - shadow=2^RATE_W-1 means exactly 1 slot per period.
- Credit update per channel, only when Enable=1:
  - Flow=1 and allow=0: cnt+1, saturating at max. An attempt at max pulses Sat next cycle.
  - Flow=0 and allow=1: cnt-1, floored at 0. No underflow and no flag.
  - Otherwise (both 1 or both 0): hold.
- Rdy is registered from cnt_next on the same edge as cnt; latency from Flow to Rdy is 1 clock. Rules for next Rdy:
  - 0 if cnt_next >= HiThr.
  - Else 1 if cnt_next <= LoThr.
  - Else hold.
  - If LoThr >= HiThr, this reduces to Rdy = (cnt_next < HiThr).
  - HiThr=0 forces Rdy=0 permanently.
- Flow asserted while Rdy=0 is still counted; the block does not mask upstream violations.
- Enable=0 also freezes Sat=0 and Rdy at its current value.
- Channels are fully independent; only ph, HiThr and LoThr are shared.

Optional Feature:
- Macro: FLOW_RATE_STATS_EN.
- Defined: per-channel 16-bit counter increments on every Sat pulse.
  - Saturates at 0xFFFF.
  - StatClr=1 zeroes all counters synchronously. A clear wins over a simultaneous increment.
- Undefined: no counter logic. StatCnt is tied to 0 and StatClr is ignored. Ports remain, so the interface is unchanged.

Decomposition:
- Package flow_rate_pkg holds:
  - Default parameter constants.
  - STAT_W=16.
  - Function bitrev(parameterised width).
  - typedef rate_t (logic [RATE_W-1:0]) via a parameterised struct/localparam helper.
- One sub-module, flow_rate_channel, instantiated NUM_CH times by generate. It contains:
  - shadow rate, allow compare, credit counter, Rdy hysteresis, Sat, optional stats.
- Top level contains ph, the period-boundary strobe and the port slicing.

Test Plan (NUM_CH=2, RATE_W=3, CNT_W=4, HiThr=8, LoThr=2 unless stated):
- Reset release, ch0 DisableRate=0, Flow=1 every cycle for 16 cycles -> cnt stays 0, Rdy=1 throughout, Sat never pulses.
- ch0 DisableRate=4, Flow=1 for 8 cycles from ph=0 -> allowed only at odd ph; cnt=4 after 8 cycles, Rdy=1.
- Continue Flow=1, rate 4 -> cnt reaches 8 at cycle 16, Rdy=0 on that edge. Flow=0 until cnt reaches 2 -> Rdy returns to 1 on that edge. Rdy stays 0 while cnt is 7..3.
- ch1 DisableRate=7, Flow=1 for 40 cycles -> cnt saturates at 15, Sat pulses each cycle after the saturating attempt, ch0 unaffected. With FLOW_RATE_STATS_EN, StatCnt[ch1] counts the pulses; StatClr zeroes it.
- Change ch0 DisableRate 0→7 at ph=3 -> allowance unchanged until ph wraps to 0, then 1 allowed slot per 8.
- Drop RstN mid-operation with cnt=6 and Rdy=0 -> immediately (asynchronously) cnt=0, Rdy=1, ph=0, no clock edge required.
